// File: rtl/cpu_width_pkg.sv
// Shared width constants, 9-bit immediate limits and buffer state type for the
// 16<->9 bit sign conversion stages.
package cpu_width_pkg;
    localparam int IN_W  = 16;
    localparam int OUT_W = 9;

    localparam logic [OUT_W-1:0] IMM9_MAX = 9'h0FF;
    localparam logic [OUT_W-1:0] IMM9_MIN = 9'h100;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } narrow_state_t;
endpackage

// File: rtl/narrow_fit_check.sv
// Purpose: narrows a 16-bit signed value to 9 bits, saturating or wrapping on overflow.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module narrow_fit_check
    import cpu_width_pkg::*;
(
    input  logic [IN_W-1:0]  data_in,
    input  logic             sat_en,
    output logic [OUT_W-1:0] data_narrow,
    output logic             ovf
);
    logic [IN_W-OUT_W:0] hi_bits;
    logic                fits;

    // The value fits only if every bit above the 9-bit sign position repeats it.
    assign hi_bits = data_in[IN_W-1:OUT_W-1];
    assign fits    = (&hi_bits) | ~(|hi_bits);

    always_comb begin
        ovf         = ~fits;
        data_narrow = data_in[OUT_W-1:0];
        if (!fits && sat_en) begin
            data_narrow = data_in[IN_W-1] ? IMM9_MIN : IMM9_MAX;
        end
    end
endmodule

// File: rtl/sign_narrow_16to9.sv
// Purpose: registered 16-to-9 bit signed narrowing with overflow status and event counter.
// Latency: one cycle from accept to out_valid.
// Backpressure: one-entry buffer; in_ready follows out_ready when full, so drain and refill share a cycle.
module sign_narrow_16to9
    import cpu_width_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  data_in,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_status
);
    narrow_state_t    state;
    narrow_state_t    state_nxt;
    logic             accept;
    logic             drain;
    logic [OUT_W-1:0] fit_dat;
    logic             fit_ovf;
    logic [CNT_W-1:0] cnt_base;

    narrow_fit_check u_fit (
        .data_in     (data_in),
        .sat_en      (sat_en),
        .data_narrow (fit_dat),
        .ovf         (fit_ovf)
    );

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (drain && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
        in_ready  = (state == EMPTY) | out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            ovf      <= 1'b0;
        end else if (accept) begin
            data_out <= fit_dat;
            ovf      <= fit_ovf;
        end
    end

    // A clear in the same cycle as a new overflow counts that overflow from zero.
    assign cnt_base = clr_status ? '0 : ovf_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (accept && fit_ovf) begin
            ovf_sticky <= 1'b1;
            ovf_count  <= (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
        end else if (clr_status) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end
    end
endmodule

// File: tb/tb_sign_narrow_16to9.sv
// Bench for sign_narrow_16to9: directed scenarios plus a randomized stream
// checked against an arithmetic reference model and an in-order queue.
module tb_sign_narrow_16to9;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic        sat_en;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  data_out;
    logic        ovf;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;
    logic        clr_status;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [8:0]  q_dat[$];
    logic        q_ovf[$];
    logic [15:0] q_in[$];
    int          exp_cnt    = 0;
    logic        exp_sticky = 1'b0;

    // Values observed just before the last clock edge of drive()
    logic        pre_in_ready;
    logic        pre_out_valid;
    logic        mdl_ready;
    logic        drained;
    logic [8:0]  drn_dat;
    logic        drn_ovf;
    logic [15:0] drn_in;
    logic [8:0]  pre_data;
    logic        pre_ovf;

    sign_narrow_16to9 #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr_status (clr_status)
    );

    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    function automatic void ref_narrow(input logic [15:0] d, input logic s,
                                       output logic [8:0] r, output logic o);
        int v;
        v = $signed(d);
        o = (v < -256) || (v > 255);
        if (o && s) r = (v > 0) ? 9'd255 : 9'h100;
        else        r = 9'(v);
    endfunction

    // Applies one cycle of stimulus and advances the model; checking is left to callers.
    task automatic drive(input logic v, input logic [15:0] d, input logic s,
                         input logic ordy, input logic clr);
        logic [8:0] rd;
        logic       ro;
        in_valid = v; data_in = d; sat_en = s; out_ready = ordy; clr_status = clr;
        #1;
        pre_in_ready  = in_ready;
        pre_out_valid = out_valid;
        pre_data      = data_out;
        pre_ovf       = ovf;
        mdl_ready     = (q_dat.size() == 0) || ordy;
        drained       = 1'b0;
        if (q_dat.size() != 0 && ordy) begin
            drained = 1'b1;
            drn_dat = q_dat.pop_front();
            drn_ovf = q_ovf.pop_front();
            drn_in  = q_in.pop_front();
        end
        if (clr) begin
            exp_sticky = 1'b0;
            exp_cnt    = 0;
        end
        if (v && mdl_ready) begin
            ref_narrow(d, s, rd, ro);
            q_dat.push_back(rd);
            q_ovf.push_back(ro);
            q_in.push_back(d);
            if (ro) begin
                exp_sticky = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; data_in = '0; sat_en = 1'b0; out_ready = 1'b0; clr_status = 1'b0;
        #25;
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || data_out !== 9'h000 || ovf !== 1'b0) begin
            $display("FAIL reset_out: out_valid=%b data_out=%h ovf=%b, want 0 000 0", out_valid, data_out, ovf);
            n_fail++;
        end
        n_tests++;
        if (ovf_sticky !== 1'b0 || ovf_count !== 8'd0) begin
            $display("FAIL reset_status: sticky=%b count=%0d, want 0 0", ovf_sticky, ovf_count);
            n_fail++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
            n_fail++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name, input logic [15:0] din[],
                             input logic sat, input logic [8:0] want[], input logic want_ovf[]);
        for (int i = 0; i < din.size(); i++) begin
            drive(1'b1, din[i], sat, 1'b1, 1'b0);
            n_tests++;
            if (pre_in_ready !== 1'b1) begin
                $display("FAIL %s_in_ready[%0d]: got %b want 1", name, i, pre_in_ready);
                n_fail++;
            end
            n_tests++;
            if (out_valid !== 1'b1 || data_out !== want[i] || ovf !== want_ovf[i]) begin
                $display("FAIL %s[%0d]: in=%h got v=%b d=%h o=%b want v=1 d=%h o=%b",
                         name, i, din[i], out_valid, data_out, ovf, want[i], want_ovf[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_in_range;
        logic [15:0] din[]  = '{16'h00FF, 16'hFF00, 16'h0000};
        logic [8:0]  want[] = '{9'h0FF, 9'h100, 9'h000};
        logic        wo[]   = '{1'b0, 1'b0, 1'b0};
        run_table("in_range", din, 1'b0, want, wo);
        n_tests++;
        if (ovf_sticky !== 1'b0 || ovf_count !== 8'd0) begin
            $display("FAIL in_range_status: sticky=%b count=%0d want 0 0", ovf_sticky, ovf_count);
            n_fail++;
        end
    endtask

    task automatic test_saturate;
        logic [15:0] din[]  = '{16'h0100, 16'h8000};
        logic [8:0]  want[] = '{9'h0FF, 9'h100};
        logic        wo[]   = '{1'b1, 1'b1};
        run_table("saturate", din, 1'b1, want, wo);
        n_tests++;
        if (ovf_sticky !== 1'b1 || ovf_count !== 8'd2) begin
            $display("FAIL saturate_status: sticky=%b count=%0d want 1 2", ovf_sticky, ovf_count);
            n_fail++;
        end
    endtask

    task automatic test_wrap;
        logic [15:0] din[]  = '{16'h0100, 16'h7E05};
        logic [8:0]  want[] = '{9'h100, 9'h005};
        logic        wo[]   = '{1'b1, 1'b1};
        run_table("wrap", din, 1'b0, want, wo);
        n_tests++;
        if (ovf_sticky !== 1'b1 || ovf_count !== 8'd4) begin
            $display("FAIL wrap_status: sticky=%b count=%0d want 1 4", ovf_sticky, ovf_count);
            n_fail++;
        end
    endtask

    task automatic test_backpressure;
        drive(1'b1, 16'h0012, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0030 + 16'(i), 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (pre_in_ready !== 1'b0) begin
                $display("FAIL bp_in_ready[%0d]: got %b want 0", i, pre_in_ready);
                n_fail++;
            end
            n_tests++;
            if (out_valid !== 1'b1 || data_out !== 9'h012 || ovf !== 1'b0) begin
                $display("FAIL bp_hold[%0d]: got v=%b d=%h o=%b want 1 012 0", i, out_valid, data_out, ovf);
                n_fail++;
            end
        end
        drive(1'b1, 16'hFF77, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (pre_in_ready !== 1'b1 || pre_data !== 9'h012) begin
            $display("FAIL bp_release: in_ready=%b drained=%h want 1 012", pre_in_ready, pre_data);
            n_fail++;
        end
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 9'h177) begin
            $display("FAIL bp_reload: got v=%b d=%h want 1 177", out_valid, data_out);
            n_fail++;
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
            n_fail++;
        end
    endtask

    task automatic test_random;
        logic [15:0] d;
        logic [8:0]  r;
        for (int i = 0; i < 400; i++) begin
            r = 9'($urandom);
            case ($urandom_range(0, 3))
                0:       d = {{7{r[8]}}, r};
                1:       d = 16'($urandom);
                2:       d = ($urandom_range(0, 1) != 0) ? 16'h0100 : 16'hFEFF;
                default: d = ($urandom_range(0, 1) != 0) ? 16'h00FF : 16'hFF00;
            endcase
            drive(1'($urandom_range(0, 3) != 0), d, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
            n_tests++;
            if (pre_in_ready !== mdl_ready) begin
                $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, pre_in_ready, mdl_ready);
                n_fail++;
            end
            if (drained) begin
                n_tests++;
                if (pre_out_valid !== 1'b1 || pre_data !== drn_dat || pre_ovf !== drn_ovf) begin
                    $display("FAIL rnd_data[%0d]: in=%h got v=%b d=%h o=%b want 1 %h %b",
                             i, drn_in, pre_out_valid, pre_data, pre_ovf, drn_dat, drn_ovf);
                    n_fail++;
                end
                if (!drn_ovf) begin
                    n_tests++;
                    if ({{7{pre_data[8]}}, pre_data} !== drn_in) begin
                        $display("FAIL rnd_sext[%0d]: got %h want %h", i, {{7{pre_data[8]}}, pre_data}, drn_in);
                        n_fail++;
                    end
                end
            end
            n_tests++;
            if (out_valid !== (q_dat.size() != 0)) begin
                $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, q_dat.size() != 0);
                n_fail++;
            end
        end
        n_tests++;
        if (ovf_sticky !== exp_sticky || int'(ovf_count) != exp_cnt) begin
            $display("FAIL rnd_status: sticky=%b count=%0d want %b %0d", ovf_sticky, ovf_count, exp_sticky, exp_cnt);
            n_fail++;
        end
    endtask

    task automatic test_status;
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, (i % 2 == 0) ? 16'h4000 + 16'(i) : 16'hB000 - 16'(i), 1'($urandom), 1'b1, 1'b0);
        end
        n_tests++;
        if (ovf_sticky !== 1'b1 || ovf_count !== 8'd255) begin
            $display("FAIL status_saturate: sticky=%b count=%0d want 1 255", ovf_sticky, ovf_count);
            n_fail++;
        end
        drive(1'b1, 16'h8000, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (ovf_sticky !== 1'b1 || ovf_count !== 8'd1) begin
            $display("FAIL status_clr_with_ovf: sticky=%b count=%0d want 1 1", ovf_sticky, ovf_count);
            n_fail++;
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (ovf_sticky !== 1'b0 || ovf_count !== 8'd0) begin
            $display("FAIL status_clr_alone: sticky=%b count=%0d want 0 0", ovf_sticky, ovf_count);
            n_fail++;
        end
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 9'h100 || ovf !== 1'b1) begin
            $display("FAIL status_clr_keeps_out: got v=%b d=%h o=%b want 1 100 1", out_valid, data_out, ovf);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || data_out !== 9'h055) begin
            $display("FAIL rst_mid_load: got v=%b d=%h want 1 055", out_valid, data_out);
            n_fail++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || data_out !== 9'h000 || ovf !== 1'b0 || ovf_count !== 8'd0) begin
            $display("FAIL rst_mid_clear: got v=%b d=%h o=%b cnt=%0d want 0 000 0 0", out_valid, data_out, ovf, ovf_count);
            n_fail++;
        end
        q_dat.delete(); q_ovf.delete(); q_in.delete();
        exp_cnt = 0; exp_sticky = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL rst_mid_after: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_in_range();
        test_saturate();
        test_wrap();
        test_backpressure();
        test_random();
        test_status();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
